// File: rtl/ysyx_25040129_axi_sram.sv
// ysyx_25040129_axi_sram
// AXI-lite style single-beat SRAM slave with independent read and write
// channels and fixed, parameterised response latencies.
//
// Handshake rule used on every channel: a transfer happens on a rising edge
// where both valid and ready are high. This slave never makes its ready
// outputs depend on the master's valid inputs. Once it raises rvalid or
// bvalid, that response and its payload are held unchanged until the
// matching ready is seen.
//
// Ports:
//   clk, rst                       clock and synchronous active-high reset
//   araddr/arvalid/arready/arsize  read address channel. arsize is accepted
//                                  but ignored: rdata is always the whole
//                                  aligned word.
//   rdata/rresp/rvalid/rready      read data channel
//   awaddr/awvalid/awready         write address channel
//   wdata/wstrb/wvalid/wready      write data channel (lane-positioned data)
//   bresp/bvalid/bready            write response channel
//
// Parameters:
//   BASE_ADDR    byte address of word 0
//   DEPTH_WORDS  number of 32-bit words (power of 2)
//   RD_LAT       cycles from the AR handshake to the first cycle of rvalid
//   WR_LAT       cycles from the write commit to the first cycle of bvalid
module ysyx_25040129_axi_sram #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          RD_LAT      = 2,
  parameter int          WR_LAT      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  input  logic [2:0]  arsize,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int          AW          = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN        = 32'(4 * DEPTH_WORDS);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [3:0]  RD_LOAD     = 4'(RD_LAT - 1);
  localparam logic [3:0]  WR_LOAD     = 4'(WR_LAT - 1);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  typedef enum logic [2:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_WAIT, W_RESP} w_state_t;

  logic [31:0] mem [DEPTH_WORDS];

  // ---------------------------------------------------------------- write side
  w_state_t    w_state, w_next;
  logic [31:0] w_addr, w_data;
  logic [3:0]  w_strb;
  logic [3:0]  w_cnt;
  logic [31:0] c_addr, c_data;
  logic [3:0]  c_strb;
  logic        w_commit;
  logic [31:0] w_off;
  logic        w_in_range;
  logic [AW-1:0] w_idx;
  logic        mem_we;

  // The commit takes each half from the live bus or from its latch. Which
  // source is used depends on which half arrived first.
  always_comb begin
    c_addr   = (w_state == W_HAVE_AW) ? w_addr : awaddr;
    c_data   = (w_state == W_HAVE_W)  ? w_data : wdata;
    c_strb   = (w_state == W_HAVE_W)  ? w_strb : wstrb;
    w_commit = ((w_state == W_IDLE)    && awvalid && wvalid) ||
               ((w_state == W_HAVE_AW) && wvalid) ||
               ((w_state == W_HAVE_W)  && awvalid);
  end

  // Unsigned subtraction wraps addresses below BASE_ADDR to large offsets.
  // As a result, one compare covers both ends of the window.
  assign w_off      = c_addr - BASE_ADDR;
  assign w_in_range = (w_off < SPAN);
  assign w_idx      = w_off[AW+1:2];
  assign mem_we     = w_commit && w_in_range && !rst;

  always_ff @(posedge clk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE: begin
        if (awvalid && wvalid) w_next = W_WAIT;
        else if (awvalid)      w_next = W_HAVE_AW;
        else if (wvalid)       w_next = W_HAVE_W;
      end
      W_HAVE_AW: if (wvalid)        w_next = W_WAIT;
      W_HAVE_W:  if (awvalid)       w_next = W_WAIT;
      W_WAIT:    if (w_cnt == 4'd0) w_next = W_RESP;
      W_RESP:    if (bready)        w_next = W_IDLE;
      default:                      w_next = W_IDLE;
    endcase
  end

  always_comb begin
    awready = (w_state == W_IDLE) || (w_state == W_HAVE_W);
    wready  = (w_state == W_IDLE) || (w_state == W_HAVE_AW);
    bvalid  = (w_state == W_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_addr <= 32'h0;
      w_data <= 32'h0;
      w_strb <= 4'h0;
      w_cnt  <= 4'd0;
      bresp  <= RESP_OKAY;
    end else begin
      if ((w_state == W_IDLE) && awvalid && !wvalid) w_addr <= awaddr;
      if ((w_state == W_IDLE) && wvalid && !awvalid) begin
        w_data <= wdata;
        w_strb <= wstrb;
      end
      if (w_commit) begin
        w_cnt <= WR_LOAD;
        bresp <= w_in_range ? RESP_OKAY : RESP_SLVERR;
      end else if ((w_state == W_WAIT) && (w_cnt != 4'd0)) begin
        w_cnt <= w_cnt - 4'd1;
      end
    end
  end

  // Single write port. The storage array has no reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (c_strb[0]) mem[w_idx][7:0]   <= c_data[7:0];
      if (c_strb[1]) mem[w_idx][15:8]  <= c_data[15:8];
      if (c_strb[2]) mem[w_idx][23:16] <= c_data[23:16];
      if (c_strb[3]) mem[w_idx][31:24] <= c_data[31:24];
    end
  end

  // ----------------------------------------------------------------- read side
  r_state_t    r_state, r_next;
  logic [31:0] r_addr;
  logic [3:0]  r_cnt;
  logic [31:0] r_off;
  logic        r_in_range;
  logic [AW-1:0] r_idx;
  logic [31:0] r_word;
  logic        r_load;

  assign r_off      = r_addr - BASE_ADDR;
  assign r_in_range = (r_off < SPAN);
  assign r_idx      = r_off[AW+1:2];
  assign r_load     = (r_state == R_WAIT) && (r_cnt == 4'd0);

  // A write that commits on the same edge as the read's data capture must
  // be visible to that read. Its enabled lanes bypass the array.
  always_comb begin
    r_word = mem[r_idx];
    if (mem_we && (w_idx == r_idx)) begin
      if (c_strb[0]) r_word[7:0]   = c_data[7:0];
      if (c_strb[1]) r_word[15:8]  = c_data[15:8];
      if (c_strb[2]) r_word[23:16] = c_data[23:16];
      if (c_strb[3]) r_word[31:24] = c_data[31:24];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (arvalid)       r_next = R_WAIT;
      R_WAIT:  if (r_cnt == 4'd0) r_next = R_RESP;
      R_RESP:  if (rready)        r_next = R_IDLE;
      default:                    r_next = R_IDLE;
    endcase
  end

  always_comb begin
    arready = (r_state == R_IDLE);
    rvalid  = (r_state == R_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= 32'h0;
      r_cnt  <= 4'd0;
      rdata  <= 32'h0;
      rresp  <= RESP_OKAY;
    end else begin
      if ((r_state == R_IDLE) && arvalid) begin
        r_addr <= araddr;
        r_cnt  <= RD_LOAD;
      end else if ((r_state == R_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (r_load) begin
        rdata <= r_in_range ? r_word : 32'h0;
        rresp <= r_in_range ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // Byte offset bits and high offset bits are deliberately not used.
  logic unused_ok;
  assign unused_ok = ^{arsize, r_off[1:0], r_off[31:AW+2], w_off[1:0], w_off[31:AW+2]};

endmodule

// File: tb/tb_ysyx_25040129_axi_sram.sv
module tb_ysyx_25040129_axi_sram;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] SPAN = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [2:0]  arsize;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int checks   = 0;
  int failures = 0;

  // scoreboard: expected read data/response, pushed before each read
  logic [31:0] exp_q[$];
  logic [1:0]  rsp_q[$];
  // reference memory keyed by word index
  logic [31:0] model_mem [int];

  ysyx_25040129_axi_sram dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready), .arsize(arsize),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  // ------------------------------------------------------------ clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------------ helpers
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit in_range(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + SPAN);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d,
                                      input logic [3:0] s);
    int i;
    logic [31:0] w;
    if (!in_range(a)) return;
    i = widx(a);
    w = model_mem.exists(i) ? model_mem[i] : 32'h0;
    for (int b = 0; b < 4; b++)
      if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    model_mem[i] = w;
  endfunction

  function automatic void push_exp(input logic [31:0] a);
    if (in_range(a)) begin
      exp_q.push_back(model_mem[widx(a)]);
      rsp_q.push_back(2'b00);
    end else begin
      exp_q.push_back(32'h0);
      rsp_q.push_back(2'b10);
    end
  endfunction

  // ------------------------------------------------------------ driver tasks
  // AW and W are presented together. The reference model is updated at the
  // commit edge, and the response is checked against the address window rule.
  task automatic write_word(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output int lat);
    int n;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while (!(awready && wready) && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    model_write(a, d, s);
    lat = 0;
    while (!bvalid && lat < 50) begin @(posedge clk); #1; lat++; end
    check("b_seen", {31'h0, bvalid}, 32'h1);
    check("bresp", {30'h0, bresp}, in_range(a) ? 32'h0 : 32'h2);
    @(posedge clk); #1;
    check("b_drop", {31'h0, bvalid}, 32'h0);
  endtask

  // The expected value comes from the front of the scoreboard. While rready
  // is held low, the response is checked for stability.
  task automatic read_word(input logic [31:0] a, input int hold, output int lat);
    int n;
    logic [31:0] got_d;
    logic [1:0]  got_r;
    araddr = a; arsize = 3'($urandom_range(0, 2));
    arvalid = 1'b1; rready = (hold == 0);
    n = 0;
    while (!arready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 50) begin @(posedge clk); #1; lat++; end
    check("r_seen", {31'h0, rvalid}, 32'h1);
    got_d = rdata;
    got_r = rresp;
    check("rdata", got_d, exp_q.pop_front());
    check("rresp", {30'h0, got_r}, {30'h0, rsp_q.pop_front()});
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check("hold_rvalid", {31'h0, rvalid}, 32'h1);
      check("hold_rdata", rdata, got_d);
      check("hold_rresp", {30'h0, rresp}, {30'h0, got_r});
      check("hold_arready", {31'h0, arready}, 32'h0);
    end
    rready = 1'b1;
    @(posedge clk); #1;
    check("r_drop", {31'h0, rvalid}, 32'h0);
    check("r_arready_back", {31'h0, arready}, 32'h1);
    rready = 1'b0;
  endtask

  // ----------------------------------------------------------------- stimulus
  initial begin
    int lat, lat_r, lat_w, seen;
    logic [31:0] rnd_addr [8];
    logic [31:0] a, d;
    logic [3:0]  s;
    logic [31:0] oor [4];

    rst = 1'b1;
    araddr = '0; arvalid = 1'b0; arsize = '0; rready = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_arready", {31'h0, arready}, 32'h1);
    check("rst_awready", {31'h0, awready}, 32'h1);
    check("rst_wready",  {31'h0, wready},  32'h1);
    check("rst_rvalid",  {31'h0, rvalid},  32'h0);
    check("rst_bvalid",  {31'h0, bvalid},  32'h0);
    check("rst_rdata",   rdata, 32'h0);
    check("rst_rresp",   {30'h0, rresp}, 32'h0);
    check("rst_bresp",   {30'h0, bresp}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // basic write then read with latency checks
    write_word(32'h8000_0004, 32'hDEAD_BEEF, 4'hF, lat);
    check("w_lat", lat, 2);
    exp_q.push_back(32'hDEAD_BEEF); rsp_q.push_back(2'b00);
    read_word(32'h8000_0004, 0, lat);
    check("r_lat", lat, 2);

    // W first, AW three cycles later, single-lane strobe
    write_word(32'h8000_0020, 32'h1122_3344, 4'hF, lat);
    wdata = 32'h00AB_0000; wstrb = 4'b0100; wvalid = 1'b1; bready = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("have_w_awready", {31'h0, awready}, 32'h1);
      check("have_w_wready",  {31'h0, wready},  32'h0);
      if (k < 2) begin @(posedge clk); #1; end
    end
    awaddr = 32'h8000_0020; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    model_write(32'h8000_0020, 32'h00AB_0000, 4'b0100);
    lat = 0;
    while (!bvalid && lat < 50) begin @(posedge clk); #1; lat++; end
    check("split_w_lat", lat, 2);
    check("split_bresp", {30'h0, bresp}, 32'h0);
    @(posedge clk); #1;
    exp_q.push_back(32'h11AB_3344); rsp_q.push_back(2'b00);
    read_word(32'h8000_0020, 0, lat);

    // zero strobe is OKAY and changes nothing
    write_word(32'h8000_0020, 32'hFFFF_FFFF, 4'h0, lat);
    exp_q.push_back(32'h11AB_3344); rsp_q.push_back(2'b00);
    read_word(32'h8000_0020, 0, lat);

    // address window edges; out-of-range writes must not alias word 0
    write_word(32'h8000_0000, 32'hCAFE_0001, 4'hF, lat);
    write_word(32'h8000_0FFC, 32'hCAFE_0FFC, 4'hF, lat);
    push_exp(32'h0000_0010);
    read_word(32'h0000_0010, 0, lat);
    write_word(32'h9000_0000, 32'h1234_5678, 4'hF, lat);
    write_word(32'h8000_1000, 32'h8765_4321, 4'hF, lat);
    write_word(32'h7FFF_FFFC, 32'h0BAD_0BAD, 4'hF, lat);
    exp_q.push_back(32'hCAFE_0001); rsp_q.push_back(2'b00);
    read_word(32'h8000_0000, 0, lat);
    exp_q.push_back(32'hCAFE_0FFC); rsp_q.push_back(2'b00);
    read_word(32'h8000_0FFE, 0, lat);
    push_exp(32'h8000_1000);
    read_word(32'h8000_1000, 0, lat);

    // response held while rready is low
    push_exp(32'h8000_0004);
    read_word(32'h8000_0004, 5, lat);

    // concurrent read and write to different words
    fork
      begin push_exp(32'h8000_0000); read_word(32'h8000_0000, 0, lat_r); end
      write_word(32'h8000_0040, 32'h4040_4040, 4'hF, lat_w);
    join
    check("conc_r_lat", lat_r, 2);
    check("conc_w_lat", lat_w, 2);

    // write committing on the read's capture edge must be visible
    write_word(32'h8000_0080, 32'hA5A5_A5A5, 4'hF, lat);
    fork
      begin
        exp_q.push_back(32'h5A5A_5A5A); rsp_q.push_back(2'b00);
        read_word(32'h8000_0080, 0, lat_r);
      end
      begin
        @(posedge clk); #1; @(posedge clk); #1;
        write_word(32'h8000_0080, 32'h5A5A_5A5A, 4'hF, lat_w);
      end
    join
    // one edge later the read must return the old word
    fork
      begin
        exp_q.push_back(32'h5A5A_5A5A); rsp_q.push_back(2'b00);
        read_word(32'h8000_0080, 0, lat_r);
      end
      begin
        @(posedge clk); #1; @(posedge clk); #1; @(posedge clk); #1;
        write_word(32'h8000_0080, 32'h0F0F_0F0F, 4'hF, lat_w);
      end
    join
    push_exp(32'h8000_0080);
    read_word(32'h8000_0080, 0, lat);

    // reset during the write wait: no response, committed data kept
    awaddr = 32'h8000_00C0; wdata = 32'h7777_1234; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    model_write(32'h8000_00C0, 32'h7777_1234, 4'hF);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_awready", {31'h0, awready}, 32'h1);
    check("mid_rst_wready",  {31'h0, wready},  32'h1);
    check("mid_rst_arready", {31'h0, arready}, 32'h1);
    check("mid_rst_bvalid",  {31'h0, bvalid},  32'h0);
    check("mid_rst_rdata",   rdata, 32'h0);
    seen = 0;
    repeat (6) begin @(posedge clk); #1; if (bvalid) seen = 1; end
    check("mid_rst_no_b", seen, 0);
    push_exp(32'h8000_00C0);
    read_word(32'h8000_00C0, 0, lat);

    // randomized traffic against the reference model
    oor[0] = 32'h0000_0010; oor[1] = 32'h9000_0000;
    oor[2] = 32'h7FFF_FFFC; oor[3] = 32'h8000_1000;
    for (int i = 0; i < 8; i++) begin
      rnd_addr[i] = BASE + {20'h0, 10'($urandom_range(0, 1023)), 2'($urandom_range(0, 3))};
      write_word(rnd_addr[i], $urandom, 4'hF, lat);
    end
    for (int it = 0; it < 40; it++) begin
      a = rnd_addr[$urandom_range(0, 7)];
      if ($urandom_range(0, 7) == 0) a = oor[$urandom_range(0, 3)];
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        write_word(a, d, s, lat);
        check("rnd_w_lat", lat, 2);
      end else begin
        push_exp(a);
        read_word(a, $urandom_range(0, 2), lat);
        check("rnd_r_lat", lat, 2);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
